// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - packet type and fetch/dispatch-side bus for fetch_buffer
package fetch_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] PC;
        logic        predict_direction;
    } IF_ID_PACKET;
endpackage

interface fetch_buffer_if #(parameter int DEPTH = 8);
    import fetch_buffer_pkg::*;

    logic                    squash;
    IF_ID_PACKET [2:0]       if_packet_in;
    logic [2:0]              d_stall;
    IF_ID_PACKET [2:0]       dis_packet_out;
    logic                    fetch_stall;
    logic [$clog2(DEPTH):0]  count;

    modport slave (
        input  squash, if_packet_in, d_stall,
        output dis_packet_out, fetch_stall, count
    );

    modport master (
        output squash, if_packet_in, d_stall,
        input  dis_packet_out, fetch_stall, count
    );
endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - three-wide circular instruction queue between fetch and dispatch
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    fetch_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    localparam cnt_t STALL_LIM = cnt_t'(DEPTH - 3);

    IF_ID_PACKET entries [DEPTH];
    ptr_t        head;
    ptr_t        tail;
    cnt_t        count_q;

    IF_ID_PACKET pkt;
    logic        deq_go;
    logic [1:0]  n_deq;
    logic        enq_go;
    logic [1:0]  n_enq;
    logic        stall;
    IF_ID_PACKET wr_pkt [3];
    logic [2:0]  wr_en;

    // Output slot 2-k shows entry head+k; dequeue walks the same order and
    // stops at the first stalled slot or after a predicted-taken branch.
    always_comb begin
        bus.dis_packet_out = '0;
        pkt                = '0;
        deq_go             = 1'b1;
        n_deq              = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (cnt_t'(k) < count_q) begin
                pkt       = entries[head + ptr_t'(k)];
                pkt.valid = 1'b1;
                bus.dis_packet_out[2-k] = pkt;
                if (deq_go && !bus.d_stall[2-k]) begin
                    n_deq = n_deq + 2'd1;
                    if (pkt.predict_direction)
                        deq_go = 1'b0;
                end else begin
                    deq_go = 1'b0;
                end
            end else begin
                deq_go = 1'b0;
            end
        end
    end

    // Compact valid input slots oldest-first; younger slots after a
    // predicted-taken branch are dropped.
    always_comb begin
        stall  = count_q > STALL_LIM;
        enq_go = !stall && !bus.squash;
        n_enq  = 2'd0;
        wr_en  = 3'b000;
        for (int j = 0; j < 3; j++)
            wr_pkt[j] = '0;
        for (int s = 2; s >= 0; s--) begin
            if (enq_go && bus.if_packet_in[s].valid) begin
                wr_pkt[n_enq] = bus.if_packet_in[s];
                wr_en[n_enq]  = 1'b1;
                n_enq         = n_enq + 2'd1;
                if (bus.if_packet_in[s].predict_direction)
                    enq_go = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (bus.squash) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + ptr_t'(n_deq);
            tail    <= tail + ptr_t'(n_enq);
            count_q <= count_q + cnt_t'(n_enq) - cnt_t'(n_deq);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        for (int j = 0; j < 3; j++) begin
            if (wr_en[j])
                entries[tail + ptr_t'(j)] <= wr_pkt[j];
        end
    end

    assign bus.fetch_stall = stall;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer against a queue model
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int DEPTH = 8;
    typedef IF_ID_PACKET [2:0] grp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fetch_buffer_if #(.DEPTH(DEPTH)) bus ();
    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    IF_ID_PACKET q[$];

    function automatic IF_ID_PACKET mk(input logic [31:0] pc, input logic pd);
        IF_ID_PACKET p;
        p                   = '0;
        p.valid             = 1'b1;
        p.PC                = pc;
        p.inst              = pc ^ 32'hdead_beef;
        p.predict_direction = pd;
        return p;
    endfunction

    // Drives one cycle and advances the model: retire accepted head entries,
    // then append the new group if the buffer had room of 3 before the edge.
    task automatic tick(input grp_t g, input logic [2:0] ds, input logic sq);
        int n_deq;
        bit stall_m;
        bus.if_packet_in = g;
        bus.d_stall      = ds;
        bus.squash       = sq;
        stall_m = (DEPTH - q.size()) < 3;
        n_deq = 0;
        for (int k = 0; k < 3; k++) begin
            if (k < q.size() && !ds[2-k]) begin
                n_deq++;
                if (q[k].predict_direction) break;
            end else begin
                break;
            end
        end
        @(posedge clock);
        if (sq) begin
            q.delete();
        end else begin
            repeat (n_deq) void'(q.pop_front());
            if (!stall_m) begin
                for (int s = 2; s >= 0; s--) begin
                    if (g[s].valid) begin
                        q.push_back(g[s]);
                        if (g[s].predict_direction) break;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.if_packet_in = '0;
        bus.d_stall = 3'b111;
        bus.squash = 1'b0;
        q.delete();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (bus.count !== 4'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", bus.count);
        end
        checks++;
        if (bus.fetch_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_fetch_stall got=%b exp=0", bus.fetch_stall);
        end
        checks++;
        if (bus.dis_packet_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", bus.dis_packet_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        tick({mk(32'h0, 1'b0), mk(32'h4, 1'b0), mk(32'h8, 1'b0)}, 3'b111, 1'b0);
        checks++;
        if (bus.count !== 4'd3) begin
            failures++;
            $display("FAIL fill_count got=%0d exp=3", bus.count);
        end
        checks++;
        if (bus.dis_packet_out[2].PC !== 32'h0 || bus.dis_packet_out[1].PC !== 32'h4 ||
            bus.dis_packet_out[0].PC !== 32'h8) begin
            failures++;
            $display("FAIL fill_pcs got=%h,%h,%h exp=0,4,8", bus.dis_packet_out[2].PC,
                     bus.dis_packet_out[1].PC, bus.dis_packet_out[0].PC);
        end
        checks++;
        if ({bus.dis_packet_out[2].valid, bus.dis_packet_out[1].valid,
             bus.dis_packet_out[0].valid} !== 3'b111) begin
            failures++;
            $display("FAIL fill_valid got=%b%b%b exp=111", bus.dis_packet_out[2].valid,
                     bus.dis_packet_out[1].valid, bus.dis_packet_out[0].valid);
        end
    endtask

    task automatic test_partial_dispatch();
        tick('0, 3'b001, 1'b0);
        checks++;
        if (bus.count !== 4'd1) begin
            failures++;
            $display("FAIL partial_count got=%0d exp=1", bus.count);
        end
        checks++;
        if (bus.dis_packet_out[2].PC !== 32'h8 || bus.dis_packet_out[2].valid !== 1'b1) begin
            failures++;
            $display("FAIL partial_head got=%h/%b exp=8/1", bus.dis_packet_out[2].PC,
                     bus.dis_packet_out[2].valid);
        end
        checks++;
        if (bus.dis_packet_out[1] !== '0 || bus.dis_packet_out[0] !== '0) begin
            failures++;
            $display("FAIL partial_empty_slots got=%h exp=0", bus.dis_packet_out[1:0]);
        end
        tick('0, 3'b000, 1'b0);
    endtask

    task automatic test_predict_cut();
        tick({mk(32'h10, 1'b0), mk(32'h14, 1'b1), mk(32'h18, 1'b0)}, 3'b111, 1'b0);
        checks++;
        if (bus.count !== 4'd2) begin
            failures++;
            $display("FAIL cut_stored got=%0d exp=2", bus.count);
        end
        checks++;
        if (bus.dis_packet_out[1].PC !== 32'h14 || bus.dis_packet_out[0].valid !== 1'b0) begin
            failures++;
            $display("FAIL cut_slots got=%h/%b exp=14/0", bus.dis_packet_out[1].PC,
                     bus.dis_packet_out[0].valid);
        end
        tick('0, 3'b000, 1'b0);
        checks++;
        if (bus.count !== 4'd0) begin
            failures++;
            $display("FAIL cut_drain got=%0d exp=0", bus.count);
        end
    endtask

    task automatic test_backpressure_wrap();
        grp_t g;
        int base;
        for (int i = 0; i < 3; i++) begin
            base = 32'h100 + 12 * i;
            g = {mk(base, 1'b0), mk(base + 4, 1'b0), mk(base + 8, 1'b0)};
            tick(g, 3'b111, 1'b0);
            checks++;
            if (bus.count !== 4'((i == 0) ? 3 : 6)) begin
                failures++;
                $display("FAIL bp_count step=%0d got=%0d exp=%0d", i, bus.count, (i == 0) ? 3 : 6);
            end
            checks++;
            if (bus.fetch_stall !== (i != 0)) begin
                failures++;
                $display("FAIL bp_fetch_stall step=%0d got=%b exp=%b", i, bus.fetch_stall, i != 0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (bus.dis_packet_out[2-k].PC !== 32'(32'h100 + 4 * (3 * i + k)) ||
                    bus.dis_packet_out[2-k].valid !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_order grp=%0d k=%0d got=%h exp=%h", i, k,
                             bus.dis_packet_out[2-k].PC, 32'h100 + 4 * (3 * i + k));
                end
            end
            tick('0, 3'b000, 1'b0);
        end
        checks++;
        if (bus.count !== 4'd0) begin
            failures++;
            $display("FAIL wrap_drain got=%0d exp=0", bus.count);
        end
    endtask

    task automatic test_squash();
        tick({mk(32'h300, 1'b0), mk(32'h304, 1'b0), mk(32'h308, 1'b0)}, 3'b111, 1'b0);
        tick({mk(32'h30c, 1'b0), mk(32'h310, 1'b0), IF_ID_PACKET'('0)}, 3'b111, 1'b0);
        checks++;
        if (bus.count !== 4'd5) begin
            failures++;
            $display("FAIL squash_setup got=%0d exp=5", bus.count);
        end
        tick({mk(32'h314, 1'b0), mk(32'h318, 1'b0), mk(32'h31c, 1'b0)}, 3'b000, 1'b1);
        checks++;
        if (bus.count !== 4'd0 || bus.dis_packet_out !== '0) begin
            failures++;
            $display("FAIL squash_clear got=%0d/%h exp=0/0", bus.count, bus.dis_packet_out);
        end
        bus.squash = 1'b0;
    endtask

    task automatic test_async_reset();
        tick({mk(32'h200, 1'b0), mk(32'h204, 1'b0), mk(32'h208, 1'b0)}, 3'b111, 1'b0);
        tick({mk(32'h20c, 1'b0), IF_ID_PACKET'('0), IF_ID_PACKET'('0)}, 3'b111, 1'b0);
        checks++;
        if (bus.count !== 4'd4) begin
            failures++;
            $display("FAIL async_setup got=%0d exp=4", bus.count);
        end
        bus.if_packet_in = '0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.count !== 4'd0 || bus.dis_packet_out !== '0 || bus.fetch_stall !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%0d/%h/%b exp=0/0/0", bus.count,
                     bus.dis_packet_out, bus.fetch_stall);
        end
        q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        grp_t g;
        IF_ID_PACKET exp_pkt;
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 3; s++) begin
                g[s] = mk($urandom, ($urandom_range(0, 5) == 0));
                g[s].valid = ($urandom_range(0, 3) != 0);
            end
            tick(g, 3'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0));
            checks++;
            if (bus.count !== 4'(q.size())) begin
                failures++;
                $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, bus.count, q.size());
            end
            checks++;
            if (bus.fetch_stall !== ((DEPTH - q.size()) < 3)) begin
                failures++;
                $display("FAIL rand_fetch_stall cyc=%0d got=%b exp=%b", c, bus.fetch_stall,
                         (DEPTH - q.size()) < 3);
            end
            for (int k = 0; k < 3; k++) begin
                exp_pkt = (k < q.size()) ? q[k] : IF_ID_PACKET'('0);
                checks++;
                if (bus.dis_packet_out[2-k] !== exp_pkt) begin
                    failures++;
                    $display("FAIL rand_slot cyc=%0d slot=%0d got=%h exp=%h", c, 2 - k,
                             bus.dis_packet_out[2-k], exp_pkt);
                end
            end
        end
        bus.squash = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_partial_dispatch();
        test_predict_cut();
        test_backpressure_wrap();
        test_squash();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end
endmodule
